// File: rtl/dmi_txn_guard.sv
//==============================================================================
// Module : dmi_txn_guard
// Single-outstanding DMI request/response guard with a sticky error latch.
// Optional response timeout enabled by defining DMI_TXN_GUARD_TIMEOUT_EN.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module dmi_txn_guard #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        up_req_valid_i,
    output logic        up_req_ready_o,
    input  logic [6:0]  up_req_addr_i,
    input  logic [1:0]  up_req_op_i,
    input  logic [31:0] up_req_data_i,
    output logic        up_resp_valid_o,
    input  logic        up_resp_ready_i,
    output logic [1:0]  up_resp_resp_o,
    output logic [31:0] up_resp_data_o,
    output logic        dn_req_valid_o,
    input  logic        dn_req_ready_i,
    output logic [6:0]  dn_req_addr_o,
    output logic [1:0]  dn_req_op_o,
    output logic [31:0] dn_req_data_o,
    input  logic        dn_resp_valid_i,
    output logic        dn_resp_ready_o,
    input  logic [1:0]  dn_resp_resp_i,
    input  logic [31:0] dn_resp_data_i,
    input  logic        err_clear_i,
    output logic [1:0]  sticky_err_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RESP    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    localparam logic [1:0] c_RESP_BUSY = 2'd3;

    state_t      state_q, state_d;
    logic [6:0]  addr_q, addr_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  resp_q, resp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  sticky_q, sticky_d;
    logic        tmo_hit;

`ifdef DMI_TXN_GUARD_TIMEOUT_EN
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = (state_q == S_RESP) && (tmo_cnt_q == c_TMO_LAST);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == S_REQ && dn_req_ready_i) begin
            tmo_cnt_d = '0;
        end else if (state_q == S_RESP) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        op_d     = op_q;
        wdata_d  = wdata_q;
        resp_d   = resp_q;
        rdata_d  = rdata_q;
        sticky_d = sticky_q;

        case (state_q)
            S_IDLE: begin
                if (up_req_valid_i) begin
                    addr_d  = up_req_addr_i;
                    op_d    = up_req_op_i;
                    wdata_d = up_req_data_i;
                    // A latched error short-circuits to busy without touching the DM.
                    if (sticky_q == 2'd0) begin
                        state_d = S_REQ;
                    end else begin
                        resp_d  = c_RESP_BUSY;
                        rdata_d = '0;
                        state_d = S_DELIVER;
                    end
                end
            end
            S_REQ: begin
                if (dn_req_ready_i) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (dn_resp_valid_i) begin
                    resp_d  = dn_resp_resp_i;
                    rdata_d = dn_resp_data_i;
                    state_d = S_DELIVER;
                end else if (tmo_hit) begin
                    resp_d  = c_RESP_BUSY;
                    rdata_d = '0;
                    state_d = S_DELIVER;
                end
            end
            default: begin
                if (up_resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // Setting takes priority over a simultaneous clear.
        if (state_q == S_RESP && state_d == S_DELIVER && resp_d[1] && sticky_q == 2'd0) begin
            sticky_d = resp_d;
        end else if (err_clear_i) begin
            sticky_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            op_q     <= '0;
            wdata_q  <= '0;
            resp_q   <= '0;
            rdata_q  <= '0;
            sticky_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            op_q     <= op_d;
            wdata_q  <= wdata_d;
            resp_q   <= resp_d;
            rdata_q  <= rdata_d;
            sticky_q <= sticky_d;
        end
    end

    // Responses outside RESP are accepted and dropped so stale beats drain.
    assign dn_resp_ready_o = !reset;
    assign up_req_ready_o  = (state_q == S_IDLE) && !reset;
    assign dn_req_valid_o  = (state_q == S_REQ);
    assign dn_req_addr_o   = addr_q;
    assign dn_req_op_o     = op_q;
    assign dn_req_data_o   = wdata_q;
    assign up_resp_valid_o = (state_q == S_DELIVER);
    assign up_resp_resp_o  = resp_q;
    assign up_resp_data_o  = rdata_q;
    assign sticky_err_o    = sticky_q;

endmodule

`default_nettype wire
